// File: rtl/memory_state_machine.sv
// Read-address sequencer: sweeps a sliding window of m consecutive words over
// a circular buffer of n words. Each window starts one word after the previous
// one, and one address is produced on every clock.
module memory_state_machine #(
  parameter int addrSize = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [addrSize-1:0] n,
  input  logic [6:0]          m,
  output logic [addrSize-1:0] state
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_t;

  localparam logic [addrSize-1:0] ONE = addrSize'(1);

  fsm_t                fsm_st, fsm_nxt;
  logic [addrSize-1:0] nReg, nReg_nxt;
  logic [6:0]          mReg, mReg_nxt;
  logic [addrSize-1:0] base, base_nxt;
  logic [6:0]          offset, offset_nxt;
  logic [addrSize-1:0] addr, addr_nxt;

  // Step a buffer index by one, wrapping to zero at the top of the buffer.
  // Wrap is done by comparison so no adder ever overflows past lim-1.
  function automatic logic [addrSize-1:0] wrap_inc(
    input logic [addrSize-1:0] v,
    input logic [addrSize-1:0] lim
  );
    return (v == lim - ONE) ? '0 : v + ONE;
  endfunction

  // True on the last word of the current window.
  function automatic logic win_end(
    input logic [6:0] off,
    input logic [6:0] len
  );
    return off == len - 7'd1;
  endfunction

  // FSM state register; reset sends the sequencer back to LOAD at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_st <= LOAD;
    else      fsm_st <= fsm_nxt;
  end

  // Next-state and next-address logic.
  always_comb begin
    fsm_nxt    = fsm_st;
    nReg_nxt   = nReg;
    mReg_nxt   = mReg;
    base_nxt   = base;
    offset_nxt = offset;
    addr_nxt   = addr;
    case (fsm_st)
      LOAD: begin
        // Geometry is sampled here only; later input changes are ignored.
        nReg_nxt   = n;
        mReg_nxt   = m;
        base_nxt   = '0;
        offset_nxt = '0;
        addr_nxt   = '0;
        fsm_nxt    = (n == '0 || m == 7'd0) ? HALT : RUN;
      end
      RUN: begin
        if (win_end(offset, mReg)) begin
          // Next window starts one word later; its first address is the new base.
          offset_nxt = '0;
          base_nxt   = wrap_inc(base, nReg);
          addr_nxt   = wrap_inc(base, nReg);
        end else begin
          offset_nxt = offset + 7'd1;
          addr_nxt   = wrap_inc(addr, nReg);
        end
      end
      HALT: begin
        // Empty buffer or empty window: park at address 0 until reset.
        addr_nxt = '0;
      end
      default: begin
        fsm_nxt = LOAD;
      end
    endcase
  end

  // Geometry and address registers, cleared asynchronously so a reset
  // mid-window discards any partial window immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nReg   <= '0;
      mReg   <= '0;
      base   <= '0;
      offset <= '0;
      addr   <= '0;
    end else begin
      nReg   <= nReg_nxt;
      mReg   <= mReg_nxt;
      base   <= base_nxt;
      offset <= offset_nxt;
      addr   <= addr_nxt;
    end
  end

  assign state = addr;

endmodule

// File: tb/tb_memory_state_machine.sv
// Bench for memory_state_machine: directed cases plus randomized geometries,
// compared against an arithmetic model of the window sweep.
module tb_memory_state_machine;

  logic       clk;
  logic       rst;
  logic [7:0] n;
  logic [6:0] m;
  logic [7:0] state;

  int total = 0;
  int bad   = 0;

  memory_state_machine #(.addrSize(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .n     (n),
    .m     (m),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Address produced on the k-th edge after reset release (k >= 1).
  // Window w covers (w+j) mod n for j = 0..m-1.
  function automatic int exp_addr(input int nv, input int mv, input int k);
    int idx;
    if (nv == 0 || mv == 0) return 0;
    idx = k - 1;
    return ((idx / mv) + (idx % mv)) % nv;
  endfunction

  // Assert reset between edges and confirm the output clears immediately and
  // stays clear across a clock edge while held.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_now", state, 0);
    @(posedge clk);
    #1;
    chk("rst_held", state, 0);
  endtask

  // Load nv/mv while in reset, release between edges, then check each edge.
  // chg_at > 0: scramble n/m shortly after that edge.
  // abort_at > 0: after checking that edge, drop reset and check the clear.
  task automatic run_seq(input string tag, input int nv, input int mv,
                         input int cycles, input int chg_at, input int abort_at);
    n = nv[7:0];
    m = mv[6:0];
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      if (k == chg_at) begin
        #2;
        n = 8'($urandom_range(0, 255));
        m = 7'($urandom_range(0, 127));
      end
      @(negedge clk);
      chk(tag, state, exp_addr(nv, mv, k));
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk({tag, "_async"}, state, 0);
        return;
      end
    end
    do_reset();
  endtask

  initial begin
    int nv, mv;
    rst = 1'b0;
    n   = 8'd0;
    m   = 7'd0;
    #10;
    chk("reset_state", state, 0);

    // Nominal sweep, long enough to cross several window boundaries.
    run_seq("nominal", 170, 16, 60, 0, 0);
    // Small buffer with wrap inside and across windows, two full periods.
    run_seq("wrap", 5, 3, 30, 0, 0);
    // Window longer than buffer.
    run_seq("m_gt_n", 3, 5, 15, 0, 0);
    // Degenerate geometries.
    run_seq("m0", 10, 0, 8, 0, 0);
    run_seq("n0", 0, 4, 8, 0, 0);
    run_seq("n1", 1, 4, 8, 0, 0);
    run_seq("m1", 6, 1, 14, 0, 0);
    // Inputs change after load: sequence must be unaffected.
    n = 8'd170;
    m = 7'd16;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      if (k == 5) begin
        #2;
        n = 8'd8;
        m = 7'd4;
      end
      @(negedge clk);
      chk("late_change", state, exp_addr(170, 16, k));
    end
    do_reset();
    // New geometry after the reset.
    run_seq("reload", 8, 4, 20, 0, 0);
    // Async reset mid-window at state 7, then restart from edge 1.
    run_seq("mid_rst", 170, 16, 20, 0, 8);
    run_seq("restart", 170, 16, 20, 0, 0);

    // Randomized geometries, some with input scrambling after load and some
    // aborted by an async reset part way through.
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 3) == 0) nv = $urandom_range(0, 255);
      else                           nv = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) mv = $urandom_range(0, 127);
      else                           mv = $urandom_range(0, 8);
      if ($urandom_range(0, 2) == 0) begin
        run_seq("rand_abort", nv, mv, 40, 0, $urandom_range(1, 39));
        run_seq("rand_after", nv, mv, 30, 0, 0);
      end else begin
        run_seq("rand", nv, mv, 40, $urandom_range(0, 20), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
